// File: rtl/bcd_display_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_display_scheduler                                           |
// | Function : time-shares one BCD-to-7-seg decoder across DIGITS held slots.  |
// |            Optional macro BLANK_LEADING_ZERO_EN blanks leading zero digits.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bcd_display_scheduler #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   output logic [3:0]            dec_code,
   input  logic [6:0]            dec_seg,
   output logic [7*DIGITS-1:0]   seg_out,
   output logic [DIGITS-1:0]     err,
   output logic                  busy,
   output logic                  done
);

   localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [SW-1:0] c_last_slot = SW'(DIGITS - 1);
   localparam logic [6:0]    c_blank     = 7'b1111111;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                r_state, w_state;
   logic [SW-1:0]         r_slot, w_slot;
   logic [4*DIGITS-1:0]   r_shadow, w_shadow;
   logic [4*DIGITS-1:0]   r_pend_data, w_pend_data;
   logic                  r_pend, w_pend;
   logic [3:0]            r_dec_code, w_dec_code;
   logic [7*DIGITS-1:0]   r_seg, w_seg;
   logic [DIGITS-1:0]     r_err, w_err;
   logic                  w_start;
   logic                  w_blank;
   logic [SW-1:0]         w_slot_m1;
   logic [3:0]            w_digit, w_next_digit;

   assign w_slot_m1 = r_slot - SW'(1);

   always_comb begin
      w_digit      = '0;
      w_next_digit = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_slot == SW'(i))    w_digit      = r_shadow[4*i +: 4];
         if (w_slot_m1 == SW'(i)) w_next_digit = r_shadow[4*i +: 4];
      end
   end

`ifdef BLANK_LEADING_ZERO_EN
   logic r_zero_run;

   // Any nonzero digit, valid or not, ends the leading-zero run.
   always_ff @(posedge clk) begin
      if (!rst_n)                                       r_zero_run <= 1'b0;
      else if (w_start)                                 r_zero_run <= 1'b1;
      else if (r_state == S_SAMPLE && w_digit != 4'd0)  r_zero_run <= 1'b0;
   end

   assign w_blank = r_zero_run && (w_digit == 4'd0) && (r_slot != '0);
`else
   assign w_blank = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_slot      <= '0;
         r_shadow    <= '0;
         r_pend_data <= '0;
         r_pend      <= 1'b0;
         r_dec_code  <= '0;
         r_seg       <= '1;
         r_err       <= '0;
      end else begin
         r_state     <= w_state;
         r_slot      <= w_slot;
         r_shadow    <= w_shadow;
         r_pend_data <= w_pend_data;
         r_pend      <= w_pend;
         r_dec_code  <= w_dec_code;
         r_seg       <= w_seg;
         r_err       <= w_err;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_slot      = r_slot;
      w_shadow    = r_shadow;
      w_pend_data = r_pend_data;
      w_pend      = r_pend;
      w_dec_code  = r_dec_code;
      w_seg       = r_seg;
      w_err       = r_err;
      w_start     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (load) w_start = 1'b1;
         end
         S_DRIVE: begin
            w_state = S_SAMPLE;
         end
         S_SAMPLE: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (r_slot == SW'(i)) begin
                  if (w_digit > 4'd9) begin
                     w_seg[7*i +: 7] = c_blank;
                     w_err[i]        = 1'b1;
                  end else if (w_blank) begin
                     w_seg[7*i +: 7] = c_blank;
                     w_err[i]        = 1'b0;
                  end else begin
                     w_seg[7*i +: 7] = dec_seg;
                     w_err[i]        = 1'b0;
                  end
               end
            end
            if (r_slot != '0) begin
               w_slot     = w_slot_m1;
               w_dec_code = w_next_digit;
               w_state    = S_DRIVE;
            end else begin
               w_state = S_DONE;
            end
         end
         default: begin
            if (load || r_pend) w_start = 1'b1;
            else                w_state = S_IDLE;
         end
      endcase

      // A fresh load always beats a queued request; the queue then empties.
      if (w_start) begin
         w_shadow   = load ? din : r_pend_data;
         w_pend     = 1'b0;
         w_slot     = c_last_slot;
         w_dec_code = w_shadow[4*DIGITS-1 -: 4];
         w_state    = S_DRIVE;
      end

      if (load && (r_state == S_DRIVE || r_state == S_SAMPLE)) begin
         w_pend      = 1'b1;
         w_pend_data = din;
      end
   end

   assign dec_code = r_dec_code;
   assign seg_out  = r_seg;
   assign err      = r_err;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bcd_display_scheduler                                        |
// | Function : directed self-checking bench with an external decoder model.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bcd_display_scheduler;

   localparam int DIGITS = 4;
   localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                          P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                          P7 = 7'b0001111, P8 = 7'b0000000, P9 = 7'b0000100,
                          PB = 7'b1111111;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                load;
   logic [4*DIGITS-1:0] din;
   logic [3:0]          dec_code;
   logic [6:0]          dec_seg;
   logic [7*DIGITS-1:0] seg_out;
   logic [DIGITS-1:0]   err;
   logic                busy;
   logic                done;

   int n_checks = 0;
   int n_fail   = 0;
   logic [27:0] prev_seg;

   always #5 clk = ~clk;

   bcd_display_scheduler #(.DIGITS(DIGITS)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .din(din), .dec_code(dec_code),
      .dec_seg(dec_seg), .seg_out(seg_out), .err(err), .busy(busy), .done(done)
   );

   // External shared decoder; codes above 9 return junk the DUT must ignore.
   always_comb begin
      case (dec_code)
         4'd0: dec_seg = 7'b0000001;
         4'd1: dec_seg = 7'b1001111;
         4'd2: dec_seg = 7'b0010010;
         4'd3: dec_seg = 7'b0000110;
         4'd4: dec_seg = 7'b1001100;
         4'd5: dec_seg = 7'b0100100;
         4'd6: dec_seg = 7'b0100000;
         4'd7: dec_seg = 7'b0001111;
         4'd8: dec_seg = 7'b0000000;
         4'd9: dec_seg = 7'b0000100;
         default: dec_seg = 7'b0110110;
      endcase
   end

   typedef struct {
      logic [15:0] din;
      logic [27:0] seg;
      logic [3:0]  err;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " seg_out"}, {4'h0, seg_out}, 32'h0FFF_FFFF);
      check({tag, " err"}, {28'h0, err}, 32'h0);
      check({tag, " busy"}, {31'h0, busy}, 32'h0);
      check({tag, " done"}, {31'h0, done}, 32'h0);
      check({tag, " dec_code"}, {28'h0, dec_code}, 32'h0);
   endtask

   task automatic do_scan(input vec_t v);
      int   cyc;
      logic code_bad;
      logic [15:0] d;
      d        = v.din;
      din      = v.din;
      load     = 1'b1;
      step();
      load     = 1'b0;
      din      = 16'hFFFF;
      cyc      = 0;
      code_bad = 1'b0;
      check("busy after load", {31'h0, busy}, 32'h1);
      while (1) begin
         if (cyc < 8 && dec_code !== d[4*(3 - cyc/2) +: 4]) code_bad = 1'b1;
         if (cyc == 2)
            check("slot3 only updated", {4'h0, seg_out}, {4'h0, v.seg[27:21], prev_seg[20:0]});
         if (done || cyc >= 20) break;
         step();
         cyc++;
      end
      check("done latency", cyc, 8);
      check("dec_code sequence", {31'h0, code_bad}, 32'h0);
      check("seg_out", {4'h0, seg_out}, {4'h0, v.seg});
      check("err", {28'h0, err}, {28'h0, v.err});
      step();
      check("busy low after done", {31'h0, busy}, 32'h0);
      check("done one cycle", {31'h0, done}, 32'h0);
      prev_seg = v.seg;
   endtask

   initial begin : main
      int   cyc;
      logic busy_low;
      logic seen_done;

      vecs[0] = '{16'h1234, {P1, P2, P3, P4}, 4'b0000};
      vecs[1] = '{16'h9A05, {P9, PB, P0, P5}, 4'b0100};
      vecs[3] = '{16'hFFFF, {PB, PB, PB, PB}, 4'b1111};
      vecs[6] = '{16'h8000, {P8, P0, P0, P0}, 4'b0000};
`ifdef BLANK_LEADING_ZERO_EN
      vecs[2] = '{16'h0070, {PB, PB, P7, P0}, 4'b0000};
      vecs[4] = '{16'h0A00, {PB, PB, P0, P0}, 4'b0100};
      vecs[5] = '{16'h0000, {PB, PB, PB, P0}, 4'b0000};
`else
      vecs[2] = '{16'h0070, {P0, P0, P7, P0}, 4'b0000};
      vecs[4] = '{16'h0A00, {P0, PB, P0, P0}, 4'b0100};
      vecs[5] = '{16'h0000, {P0, P0, P0, P0}, 4'b0000};
`endif

      rst_n = 1'b0;
      load  = 1'b0;
      din   = '0;
      step();
      step();
      check_reset_values("reset");
      rst_n    = 1'b1;
      prev_seg = 28'hFFFFFFF;
      step();

      for (int i = 0; i < 7; i++) do_scan(vecs[i]);

      // Requests during a scan queue up; only the latest one survives.
      din = 16'h1111; load = 1'b1; step(); load = 1'b0;
      step(); step();
      din = 16'h3333; load = 1'b1; step(); load = 1'b0;
      step();
      din = 16'h2222; load = 1'b1; step(); load = 1'b0;
      cyc      = 5;
      busy_low = 1'b0;
      while (!done && cyc < 40) begin
         step();
         cyc++;
         if (!busy) busy_low = 1'b1;
      end
      check("queued: first done", cyc, 8);
      check("queued: first seg", {4'h0, seg_out}, {4'h0, P1, P1, P1, P1});
      step();
      cyc++;
      check("queued: done drops", {31'h0, done}, 32'h0);
      while (!done && cyc < 40) begin
         if (!busy) busy_low = 1'b1;
         step();
         cyc++;
      end
      check("queued: second done", cyc, 17);
      check("queued: busy held", {31'h0, busy_low}, 32'h0);
      check("queued: latest wins", {4'h0, seg_out}, {4'h0, P2, P2, P2, P2});

      // Load arriving in the DONE cycle restarts without going idle.
      din = 16'h4321; load = 1'b1; step(); load = 1'b0;
      check("done-load busy", {31'h0, busy}, 32'h1);
      check("done-load dec_code", {28'h0, dec_code}, 32'h4);
      cyc = 0;
      while (!done && cyc < 20) begin
         step();
         cyc++;
      end
      check("done-load latency", cyc, 8);
      check("done-load seg", {4'h0, seg_out}, {4'h0, P4, P3, P2, P1});
      step();

      // Reset in the middle of a scan.
      din = 16'h5678; load = 1'b1; step(); load = 1'b0;
      step(); step(); step(); step();
      rst_n = 1'b0;
      step();
      check_reset_values("mid-scan reset");
      rst_n     = 1'b1;
      seen_done = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (done || busy) seen_done = 1'b1;
      end
      check("no activity after reset", {31'h0, seen_done}, 32'h0);
      prev_seg = 28'hFFFFFFF;
      do_scan(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bcd_display_scheduler.md
Name: bcd_display_scheduler

Overview:
Time-shares one external combinational BCD-to-7-segment decoder (4-bit code in, active-low segments [0:6] out) across DIGITS display slots. On a load request it latches a packed BCD word and walks the slots MSB to LSB. For each slot it drives the decoder, samples the result, and holds it in a per-slot segment register. It flags non-BCD digits per slot, replacing a separate decoder and range comparator per digit on the board top.

Parameters:
DIGITS, 4, number of display slots (1..8); slot i uses din[4i+3:4i] and seg_out[7i+6:7i].

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
load  input  1  request: latch din and refresh all slots
din  input  4*DIGITS  packed BCD digits, slot 0 in LSBs
dec_code  output  4  code driven to the shared decoder
dec_seg  input  7  decoder result for dec_code, bit order [0:6], active low
seg_out  output  7*DIGITS  held segment pattern per slot, active low
err  output  DIGITS  err[i]=1 when slot i digit > 9 in the last completed scan
busy  output  1  scan in progress or pending
done  output  1  one-cycle pulse when a scan completes

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on rising clk). Reset overrides everything, including mid-scan.
- Reset values: seg_out all 1s (blank), err 0, busy 0, done 0, dec_code 0, shadow 0, pending 0, state IDLE.
- States: IDLE, DRIVE, SAMPLE, DONE. slot index runs DIGITS-1 down to 0.
- IDLE: if load=1, then shadow<=din, slot<=DIGITS-1, dec_code<=din slot digit, state<=DRIVE. busy=1 from that edge.
- DRIVE: one settle cycle with dec_code stable; next state SAMPLE.
- SAMPLE, at the end of the cycle:
  - digit ≤ 9: seg_out[slot]<=dec_seg and err[slot]<=0.
  - digit > 9: seg_out[slot]<=7'b1111111 and err[slot]<=1. dec_seg is ignored.
  - If slot>0: slot decrements, dec_code<=next shadow digit, state DRIVE.
  - Otherwise: state DONE.
- DONE: done=1 for exactly this cycle.
  - If pending (or load=1 this cycle): shadow<=pending buffer (or din if load=1 now), pending cleared, restart at DRIVE slot DIGITS-1. busy stays 1.
  - Else: IDLE, busy=0.
- Latency: 2*DIGITS cycles DRIVE/SAMPLE plus 1 DONE. With DIGITS=4, load sampled at edge E0 gives done high between E8 and E9, busy low after E9.
- load while busy (DRIVE/SAMPLE): pending<=1, pending buffer<=din; the latest request wins. The current scan is never aborted.
- seg_out slots not yet rescanned keep their previous values. Each slot updates atomically at its SAMPLE edge.
- dec_code holds its last value in IDLE.

Optional Feature:
BLANK_LEADING_ZERO_EN.
- Defined:
  - A zero_run flag is set at scan start and cleared by any nonzero digit, including invalid digits.
  - A slot with digit 0, zero_run=1 and slot≠0 is stored as 1111111 with err 0.
  - Slot 0 always shows its digit.
- Undefined: zeros decode normally. zero_run logic is absent.

Test Plan:
1. rst_n=0 for 2 cycles, then 1 -> seg_out=all 1s, err=0, busy=0, done=0, dec_code=0.
2. DIGITS=4, din=16'h1234, load 1 cycle at E0 -> dec_code 1,2,3,4 each held 2 cycles; seg_out slots 3..0 = 1001111, 0010010, 0000110, 1001100; err=0000; done pulse after E8; busy low after E9.
3. din=16'h9A05, load -> err=4'b0100; slot2=1111111; slot3=0000100 (9); slot1=0000001; slot0=0100100.
4. load 16'h1111 at E0, load 16'h2222 at E3 -> first scan completes with 1s; second scan starts immediately from DONE; busy stays high continuously; two done pulses; final seg_out all 0010010.
5. load 16'h5678, rst_n=0 at E5 -> next edge gives reset values; no done pulse; subsequent load behaves as scenario 2.
6. din=16'h0070: with BLANK_LEADING_ZERO_EN -> slots 3,2 = 1111111, slot1 = 0001111, slot0 = 0000001. Without it -> slots 3,2 = 0000001.
